// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Initiator side of the data-memory port. Accepts one MIPS load/store request
// at a time (LB/LBU/LH/LHU/LW/SB/SH/SW), drives the word-addressed memory with
// word address, byte-lane select and a one-cycle write or read strobe, then
// returns a formatted response (lane extract plus sign/zero extension).
// Misaligned accesses and the illegal size code are answered with resp_err
// and never reach the memory.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we, req_op        1=store; op[1:0] size 00/01/10 (11 illegal), op[2] unsigned load
//   req_addr, req_wdata   byte address, right-aligned store data
//   resp_valid/resp_ready response handshake, response held until taken
//   resp_rdata, resp_err  formatted load data (0 for stores/errors), error flag
//   mem_addr, mem_wdata   word address, lane-replicated store data
//   mem_sel               byte enables, sel[0] = bits 7:0
//   mem_str, mem_ld       one-cycle write / read strobes
//   mem_rdata             memory read data, valid one clock after mem_ld
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int MEM_ADDR_BITS = 10,
   parameter int MEM_DATA_BITS = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [2:0]               req_op,
   input  logic [31:0]              req_addr,
   input  logic [31:0]              req_wdata,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [31:0]              resp_rdata,
   output logic                     resp_err,
   output logic [MEM_ADDR_BITS-1:0] mem_addr,
   output logic [MEM_DATA_BITS-1:0] mem_wdata,
   output logic [3:0]               mem_sel,
   output logic                     mem_str,
   output logic                     mem_ld,
   input  logic [MEM_DATA_BITS-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t      state_r;
   logic [2:0]  op_r;
   logic [1:0]  off_r;
   logic        we_r;

   // Address bits above the memory size wrap and are deliberately dropped.
   logic unused_addr_s;
   assign unused_addr_s = ^req_addr[31:MEM_ADDR_BITS+2];

   // Illegal size or an address not aligned to the access size.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = off[0];
         2'b10:   misaligned = (off != 2'b00);
         default: misaligned = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   lane_sel = 4'b0001 << off;
         2'b01:   lane_sel = off[1] ? 4'b1100 : 4'b0011;
         2'b10:   lane_sel = 4'b1111;
         default: lane_sel = 4'b0000;
      endcase
   endfunction

   // Store data is replicated so the memory only needs the sel mask.
   function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         2'b00:   lane_wdata = {4{wd[7:0]}};
         2'b01:   lane_wdata = {2{wd[15:0]}};
         default: lane_wdata = wd;
      endcase
   endfunction

   function automatic logic [31:0] fmt_load(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[{off, 3'b000} +: 8];
      h = off[1] ? d[31:16] : d[15:0];
      case (op[1:0])
         2'b00:   fmt_load = op[2] ? {24'h000000, b} : {{24{b[7]}}, b};
         2'b01:   fmt_load = op[2] ? {16'h0000, h} : {{16{h[15]}}, h};
         2'b10:   fmt_load = d;
         default: fmt_load = 32'h0000_0000;
      endcase
   endfunction

   // Request FSM with all outputs registered; strobes and sel live only in ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         op_r       <= 3'b000;
         off_r      <= 2'b00;
         we_r       <= 1'b0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0000_0000;
         resp_err   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_sel    <= 4'b0000;
         mem_str    <= 1'b0;
         mem_ld     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid && req_ready) begin
                  op_r      <= req_op;
                  off_r     <= req_addr[1:0];
                  we_r      <= req_we;
                  req_ready <= 1'b0;
                  if (misaligned(req_op[1:0], req_addr[1:0])) begin
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0000_0000;
                     resp_valid <= 1'b1;
                     state_r    <= RESP;
                  end else begin
                     mem_addr  <= req_addr[MEM_ADDR_BITS+1:2];
                     mem_sel   <= lane_sel(req_op[1:0], req_addr[1:0]);
                     mem_wdata <= lane_wdata(req_op[1:0], req_wdata);
                     mem_str   <= req_we;
                     mem_ld    <= ~req_we;
                     resp_err  <= 1'b0;
                     state_r   <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               mem_str <= 1'b0;
               mem_ld  <= 1'b0;
               mem_sel <= 4'b0000;
               if (we_r) begin
                  resp_rdata <= 32'h0000_0000;
                  resp_valid <= 1'b1;
                  state_r    <= RESP;
               end else begin
                  state_r <= CAPTURE;
               end
            end
            CAPTURE: begin
               // Memory answers one clock after the read strobe.
               resp_rdata <= fmt_load(op_r, off_r, mem_rdata);
               resp_valid <= 1'b1;
               state_r    <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_rdata <= 32'h0000_0000;
                  req_ready  <= 1'b1;
                  state_r    <= IDLE;
               end
            end
            default: begin
               state_r   <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit: a small word memory honours the
// strobes, and a byte-array reference model predicts every response.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_op = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_sel;
   logic        mem_str;
   logic        mem_ld;
   logic [31:0] mem_rdata = 32'h0;

   int total = 0;
   int bad = 0;

   logic [31:0] ram [0:1023];
   logic [7:0]  ref_bytes [0:4095];

   // observations of the most recent request
   logic [31:0] obs_rdata, obs_rdata_end, obs_wdata;
   logic        obs_err;
   logic [3:0]  obs_sel;
   logic [9:0]  obs_addr;
   int          obs_lat, obs_str_cnt, obs_ld_cnt;

   mem_access_unit #(.MEM_ADDR_BITS(10), .MEM_DATA_BITS(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
      .mem_str(mem_str), .mem_ld(mem_ld), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // attached memory: sel-masked write, registered read with unselected lanes zeroed
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_str && mem_sel[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
      if (mem_ld)
         mem_rdata <= ram[mem_addr] & {{8{mem_sel[3]}}, {8{mem_sel[2]}}, {8{mem_sel[1]}}, {8{mem_sel[0]}}};
      else
         mem_rdata <= 32'h0;
   end

   // reference model: byte-addressed memory of 4096 bytes
   task automatic model(input bit we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] e_rdata, output bit e_err,
                        output logic [3:0] e_sel, output logic [31:0] e_wdata, output int e_lat);
      int unsigned a, n;
      logic [31:0] v, m;
      a = addr & 32'hFFF;
      n = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
      e_err = (op[1:0] == 2'd3) || ((a % n) != 0);
      e_rdata = 32'h0; e_sel = 4'h0; e_wdata = 32'h0;
      if (e_err) begin
         e_lat = 1;
      end else begin
         m = ((32'd1 << n) - 32'd1) << (a % 4);
         e_sel = m[3:0];
         e_wdata = (n == 1) ? wd[7:0] * 32'h01010101 : (n == 2) ? wd[15:0] * 32'h00010001 : wd;
         if (we) begin
            for (int k = 0; k < int'(n); k++) ref_bytes[a + k] = 8'((wd >> (8 * k)) & 32'hFF);
            e_lat = 2;
         end else begin
            v = 32'h0;
            for (int k = 0; k < int'(n); k++) v = v | (32'(ref_bytes[a + k]) << (8 * k));
            if (!op[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e_rdata = v;
            e_lat = 3;
         end
      end
   endtask

   task automatic sample_mem();
      if (mem_str) obs_str_cnt++;
      if (mem_ld) obs_ld_cnt++;
      if (mem_str || mem_ld) begin
         obs_sel = mem_sel; obs_addr = mem_addr; obs_wdata = mem_wdata;
      end
   endtask

   // one complete transaction; stall = cycles resp_ready is held low after resp_valid
   task automatic do_req(input bit we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input int stall);
      obs_str_cnt = 0; obs_ld_cnt = 0; obs_sel = 4'h0; obs_addr = 10'h0; obs_wdata = 32'h0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_op = 3'($urandom);
      obs_lat = 1;
      sample_mem();
      while (!resp_valid && obs_lat < 10) begin
         @(posedge clk); #1;
         obs_lat++;
         sample_mem();
      end
      obs_rdata = resp_rdata; obs_err = resp_err;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         sample_mem();
      end
      obs_rdata_end = resp_rdata;
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
      total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_resp_rdata got=%h want=0", resp_rdata); end
      total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
      total++; if ({mem_str, mem_ld, mem_sel} !== 6'b0) begin bad++; $display("FAIL reset_strobes got=%b%b%b want=0", mem_str, mem_ld, mem_sel); end
      total++; if ({mem_addr, mem_wdata} !== 42'h0) begin bad++; $display("FAIL reset_mem_bus got=%h/%h want=0", mem_addr, mem_wdata); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
   endtask

   task automatic test_store_word();
      logic [31:0] er, ew; bit ee; logic [3:0] es; int el;
      model(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, er, ee, es, ew, el);
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
      total++; if (obs_addr !== 10'd4) begin bad++; $display("FAIL sw_addr got=%0d want=4", obs_addr); end
      total++; if (obs_sel !== 4'b1111) begin bad++; $display("FAIL sw_sel got=%b want=1111", obs_sel); end
      total++; if (obs_str_cnt !== 1 || obs_ld_cnt !== 0) begin bad++; $display("FAIL sw_strobes got str=%0d ld=%0d want 1/0", obs_str_cnt, obs_ld_cnt); end
      total++; if (obs_lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d want=2", obs_lat); end
      total++; if (obs_err !== 1'b0 || obs_rdata !== 32'h0) begin bad++; $display("FAIL sw_resp got err=%b rdata=%h want 0/0", obs_err, obs_rdata); end
   endtask

   task automatic test_load_extend();
      logic [31:0] er, ew; bit ee; logic [3:0] es; int el;
      logic [2:0]  ops   [5] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101};
      logic [31:0] addrs [5] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h12};
      logic [31:0] wants [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00000001, 32'hFFFF80FF, 32'h000080FF};
      model(1'b1, 3'b010, 32'h10, 32'h80FF7F01, er, ee, es, ew, el);
      do_req(1'b1, 3'b010, 32'h10, 32'h80FF7F01, 0);
      for (int i = 0; i < 5; i++) begin
         model(1'b0, ops[i], addrs[i], 32'h0, er, ee, es, ew, el);
         do_req(1'b0, ops[i], addrs[i], 32'h0, 0);
         total++; if (obs_rdata !== wants[i]) begin bad++; $display("FAIL load_ext[%0d] got=%h want=%h", i, obs_rdata, wants[i]); end
      end
      total++; if (obs_sel !== 4'b1100) begin bad++; $display("FAIL lhu_sel got=%b want=1100", obs_sel); end
      total++; if (obs_lat !== 3 || obs_ld_cnt !== 1) begin bad++; $display("FAIL load_latency got lat=%0d ld=%0d want 3/1", obs_lat, obs_ld_cnt); end
   endtask

   task automatic test_byte_store();
      logic [31:0] er, ew; bit ee; logic [3:0] es; int el;
      model(1'b1, 3'b000, 32'h11, 32'h000000AB, er, ee, es, ew, el);
      do_req(1'b1, 3'b000, 32'h11, 32'h000000AB, 0);
      total++; if (obs_wdata !== 32'hABABABAB) begin bad++; $display("FAIL sb_wdata got=%h want=ABABABAB", obs_wdata); end
      total++; if (obs_sel !== 4'b0010) begin bad++; $display("FAIL sb_sel got=%b want=0010", obs_sel); end
      model(1'b0, 3'b010, 32'h10, 32'h0, er, ee, es, ew, el);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
      total++; if (obs_rdata !== 32'h80FFAB01) begin bad++; $display("FAIL sb_readback got=%h want=80FFAB01", obs_rdata); end
   endtask

   task automatic test_errors();
      logic [31:0] er, ew; bit ee; logic [3:0] es; int el;
      bit          wes   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [2:0]  ops   [4] = '{3'b001, 3'b010, 3'b011, 3'b010};
      logic [31:0] addrs [4] = '{32'h11, 32'h12, 32'h10, 32'h12};
      for (int i = 0; i < 4; i++) begin
         model(wes[i], ops[i], addrs[i], 32'h12345678, er, ee, es, ew, el);
         do_req(wes[i], ops[i], addrs[i], 32'h12345678, 1);
         total++; if (obs_err !== 1'b1 || obs_lat !== 1) begin bad++; $display("FAIL err[%0d] got err=%b lat=%0d want 1/1", i, obs_err, obs_lat); end
         total++; if (obs_str_cnt !== 0 || obs_ld_cnt !== 0 || obs_rdata !== 32'h0) begin bad++; $display("FAIL err_noaccess[%0d] got str=%0d ld=%0d rdata=%h want 0", i, obs_str_cnt, obs_ld_cnt, obs_rdata); end
      end
   endtask

   task automatic test_backpressure();
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h10;
      @(posedge clk); #1;
      req_we = 1'b1; req_op = 3'b000; req_addr = 32'h20; req_wdata = 32'h55;  // held offer, must be ignored
      n = 0;
      while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_timeout got=%b want=1", resp_valid); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if (resp_valid !== 1'b1 || resp_rdata !== 32'h80FFAB01 || req_ready !== 1'b0 || mem_str !== 1'b0 || mem_ld !== 1'b0) begin
            bad++; $display("FAIL bp_hold[%0d] got valid=%b rdata=%h ready=%b str=%b ld=%b want 1/80FFAB01/0/0/0", i, resp_valid, resp_rdata, req_ready, mem_str, mem_ld);
         end
      end
      @(negedge clk); req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
      total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h10;
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #1;  // now capturing
      rst_n = 1'b0; #1;
      total++; if (resp_valid !== 1'b0 || mem_ld !== 1'b0 || mem_str !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL midop_reset got valid=%b ld=%b str=%b ready=%b want 0/0/0/1", resp_valid, mem_ld, mem_str, req_ready);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL midop_no_resp got=%b want=0", resp_valid); end
      end
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
      total++; if (obs_rdata !== 32'h80FFAB01) begin bad++; $display("FAIL midop_recover got=%h want=80FFAB01", obs_rdata); end
   endtask

   task automatic test_random();
      logic [31:0] er, ew, addr, wd; bit ee; logic [3:0] es; int el; bit we; logic [2:0] op;
      for (int t = 0; t < 300; t++) begin
         we = 1'($urandom);
         op = 3'($urandom);
         addr = ($urandom & 32'hFFFF_F03F) | 32'h0000_0100;  // random high bits exercise the wrap
         wd = $urandom;
         model(we, op, addr, wd, er, ee, es, ew, el);
         do_req(we, op, addr, wd, $urandom_range(0, 2));
         total++;
         if (obs_err !== ee || obs_rdata !== er || obs_rdata_end !== er || obs_lat !== el) begin
            bad++; $display("FAIL rnd[%0d] op=%b we=%b a=%h got err=%b rd=%h/%h lat=%0d want err=%b rd=%h lat=%0d",
                            t, op, we, addr, obs_err, obs_rdata, obs_rdata_end, obs_lat, ee, er, el);
         end
         total++;
         if (obs_str_cnt !== ((!ee && we) ? 1 : 0) || obs_ld_cnt !== ((!ee && !we) ? 1 : 0) || obs_sel !== es ||
             (!ee && obs_addr !== addr[11:2]) || (!ee && we && obs_wdata !== ew)) begin
            bad++; $display("FAIL rnd_bus[%0d] got str=%0d ld=%0d sel=%b addr=%h wd=%h want sel=%b addr=%h wd=%h",
                            t, obs_str_cnt, obs_ld_cnt, obs_sel, obs_addr, obs_wdata, es, addr[11:2], ew);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
      for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'h0;
      test_reset();
      test_store_word();
      test_load_extend();
      test_byte_store();
      test_errors();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
